// File: rtl/custom_fifo_rd_packer_pkg.sv
// Shared sizing defaults and lane-index helpers for the FIFO read-side packer.
// Optional partial-beat flush is enabled by defining PACK_TIMEOUT_EN.
package custom_fifo_pkg;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned PACK_DEF     = 4;

  // Lane index never narrower than one bit, even when PACK <= 2.
  function automatic int unsigned idx_width(input int unsigned pack);
    return (pack > 2) ? $clog2(pack) : 1;
  endfunction

  typedef logic [idx_width(PACK_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/custom_fifo_rd_packer_if.sv
// FIFO read port plus packed valid/ready output stream of the read-side packer.
// Shared by builds with and without PACK_TIMEOUT_EN.
interface custom_fifo_rd_packer_if
  import custom_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned PACK     = PACK_DEF
) ();

  logic [DATASIZE-1:0]      fifo_dout_i;
  logic                     fifo_empty_i;
  logic                     fifo_ren_o;
  logic [DATASIZE*PACK-1:0] m_data_o;
  logic [PACK-1:0]          m_keep_o;
  logic                     m_valid_o;
  logic                     m_ready_i;

  modport master (
    input  fifo_dout_i, fifo_empty_i, m_ready_i,
    output fifo_ren_o, m_data_o, m_keep_o, m_valid_o
  );

  modport slave (
    output fifo_dout_i, fifo_empty_i, m_ready_i,
    input  fifo_ren_o, m_data_o, m_keep_o, m_valid_o
  );

endinterface

// File: rtl/custom_fifo_rd_packer_idle_timer.sv
// Saturating idle counter that ages a partially packed beat.
// Only compiled when PACK_TIMEOUT_EN is defined.
`ifdef PACK_TIMEOUT_EN
module custom_pack_idle_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(TIMEOUT));

endmodule
`endif

// File: rtl/custom_fifo_rd_packer.sv
// Pops FWFT FIFO words and packs PACK of them (lane 0 = oldest) into one output beat.
// Define PACK_TIMEOUT_EN to flush partial beats after TIMEOUT idle cycles.
module custom_fifo_rd_packer
  import custom_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned PACK     = PACK_DEF,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   rclk_i,
  input  logic                   rrst_i,
  custom_fifo_rd_packer_if.master bus
);

  localparam int unsigned     IDXW     = idx_width(PACK);
  localparam int unsigned     ACCN     = (PACK > 1) ? PACK - 1 : 1;
  localparam int unsigned     BEATW    = DATASIZE * PACK;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACK - 1);

  if (PACK == 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("custom_fifo_rd_packer: PACK and TIMEOUT must be >= 1");
  end

  logic [IDXW-1:0]     idx;
  logic [DATASIZE-1:0] acc [ACCN];
  logic [BEATW-1:0]    data_q;
  logic [PACK-1:0]     keep_q;
  logic                valid_q;

  logic             out_free;
  logic             last;
  logic             pop;
  logic             load;
  logic [BEATW-1:0] beat_full;

  assign out_free = !valid_q || bus.m_ready_i;
  assign last     = (idx == LAST_IDX);
  // The final lane may only pop when the output register can take the beat.
  assign pop      = !rrst_i && !bus.fifo_empty_i && (!last || out_free);
  assign load     = pop && last;

  always_comb begin
    beat_full = '0;
    for (int unsigned i = 0; i < PACK - 1; i++) begin
      beat_full[i*DATASIZE +: DATASIZE] = acc[i];
    end
    beat_full[(PACK-1)*DATASIZE +: DATASIZE] = bus.fifo_dout_i;
  end

`ifdef PACK_TIMEOUT_EN
  logic             expired;
  logic             flush;
  logic [BEATW-1:0] beat_part;
  logic [PACK-1:0]  keep_part;

  // A pop always takes priority over a flush in the same cycle.
  assign flush = expired && out_free && !pop && (idx != '0);

  custom_pack_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk     (rclk_i),
    .rst     (rrst_i),
    .clr     (pop || (idx == '0) || flush),
    .expired (expired)
  );

  always_comb begin
    beat_part = '0;
    keep_part = '0;
    for (int unsigned i = 0; i < PACK - 1; i++) begin
      if (IDXW'(i) < idx) begin
        beat_part[i*DATASIZE +: DATASIZE] = acc[i];
        keep_part[i]                      = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      idx     <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < ACCN; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (load) begin
        data_q  <= beat_full;
        keep_q  <= '1;
        valid_q <= 1'b1;
`ifdef PACK_TIMEOUT_EN
      end else if (flush) begin
        data_q  <= beat_part;
        keep_q  <= keep_part;
        valid_q <= 1'b1;
`endif
      end else if (bus.m_ready_i) begin
        valid_q <= 1'b0;
      end

      if (pop) begin
        if (last) begin
          idx <= '0;
          for (int unsigned i = 0; i < ACCN; i++) begin
            acc[i] <= '0;
          end
        end else begin
          for (int unsigned i = 0; i < ACCN; i++) begin
            if (idx == IDXW'(i)) begin
              acc[i] <= bus.fifo_dout_i;
            end
          end
          idx <= idx + 1'b1;
        end
`ifdef PACK_TIMEOUT_EN
      end else if (flush) begin
        idx <= '0;
        for (int unsigned i = 0; i < ACCN; i++) begin
          acc[i] <= '0;
        end
`endif
      end
    end
  end

  assign bus.fifo_ren_o = pop;
  assign bus.m_data_o   = data_q;
  assign bus.m_keep_o   = keep_q;
  assign bus.m_valid_o  = valid_q;

endmodule

// File: tb/tb_custom_fifo_rd_packer.sv
// Self-checking bench for custom_fifo_rd_packer (DATASIZE=8, PACK=4, TIMEOUT=16).
// Expectations adapt when PACK_TIMEOUT_EN is defined.
module tb_custom_fifo_rd_packer;

  localparam int DS = 8;
  localparam int PK = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  custom_fifo_rd_packer_if #(.DATASIZE(DS), .PACK(PK)) bus ();

  custom_fifo_rd_packer #(
    .DATASIZE(DS),
    .PACK    (PK),
    .TIMEOUT (TO)
  ) dut (
    .rclk_i(clk),
    .rrst_i(rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q [$];
  logic [31:0] beats  [$];
  bit          ren_hist [$];
  bit          ready = 1'b0;
  bit          gate  = 1'b0;

  // Reference model: words waiting for a beat, plus the output slot.
  logic [7:0]  m_part [$];
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  int          m_idle;

  typedef struct {
    string       name;
    int          nwords;
    logic [7:0]  base;
    logic [7:0]  step;
    bit          sparse;
    int          stall;
    int          exp_run;
    int          exp_nbeats;
    logic [31:0] exp_beat [3];
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check ren, step model, check outputs next negedge.
  task automatic tick();
    logic       exp_ren;
    logic       ren_s;
    logic       free;
    logic [7:0] word;
    bus.fifo_empty_i = (fifo_q.size() == 0) || gate;
    bus.fifo_dout_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    bus.m_ready_i    = ready;
    #1;
    word    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    free    = !m_valid || ready;
    exp_ren = !rst && !bus.fifo_empty_i && ((m_part.size() != PK - 1) || free);
    chk("ren", {31'b0, bus.fifo_ren_o}, {31'b0, exp_ren});
    ren_s = bus.fifo_ren_o;
    ren_hist.push_back(ren_s);
    if (!rst && bus.m_valid_o && ready) beats.push_back(bus.m_data_o);

    if (rst) begin
      m_part.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_keep  = '0;
      m_idle  = 0;
    end else begin
      if (m_valid && ready) m_valid = 1'b0;
      if (exp_ren) begin
        m_part.push_back(word);
        m_idle = 0;
        if (m_part.size() == PK) begin
          m_data = '0;
          foreach (m_part[i]) m_data[i*DS +: DS] = m_part[i];
          m_keep  = '1;
          m_valid = 1'b1;
          m_part.delete();
        end
      end else if (m_part.size() == 0) begin
        m_idle = 0;
      end
`ifdef PACK_TIMEOUT_EN
      else if (m_idle == TO && free) begin
        m_data = '0;
        foreach (m_part[i]) m_data[i*DS +: DS] = m_part[i];
        m_keep  = 4'((1 << m_part.size()) - 1);
        m_valid = 1'b1;
        m_part.delete();
        m_idle  = 0;
      end else if (m_idle < TO) begin
        m_idle++;
      end
`endif
    end

    @(posedge clk);
    @(negedge clk);
    if (ren_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    chk("m_valid", {31'b0, bus.m_valid_o}, {31'b0, m_valid});
    chk("m_data", bus.m_data_o, m_data);
    chk("m_keep", {28'b0, bus.m_keep_o}, {28'b0, m_keep});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    gate  = 1'b0;
    ready = 1'b0;
    fifo_q.delete();
    tick();
    rst = 1'b0;
    beats.delete();
    ren_hist.delete();
  endtask

  initial begin
    int          run;
    bit          broken;
    int          first;
    logic [31:0] first_data;
    logic [3:0]  first_keep;

    bus.fifo_empty_i = 1'b1;
    bus.fifo_dout_i  = '0;
    bus.m_ready_i    = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_idle  = 0;

    vecs[0] = '{"basic",  8, 8'h11, 8'h11, 1'b0,  0, 8, 2, '{32'h44332211, 32'h88776655, 32'h0}};
    vecs[1] = '{"stall", 12, 8'h01, 8'h01, 1'b0, 20, 7, 3, '{32'h04030201, 32'h08070605, 32'h0C0B0A09}};
    vecs[2] = '{"sparse", 8, 8'h11, 8'h11, 1'b1,  0, 1, 2, '{32'h44332211, 32'h88776655, 32'h0}};

    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_valid", {31'b0, bus.m_valid_o}, 32'h0);
    chk("reset_data", bus.m_data_o, 32'h0);
    chk("reset_keep", {28'b0, bus.m_keep_o}, 32'h0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].nwords; k++)
        fifo_q.push_back(8'(vecs[v].base + k * vecs[v].step));
      ready = (vecs[v].stall == 0);
      for (int c = 0; c < 60; c++) begin
        if (vecs[v].stall != 0 && c == vecs[v].stall) begin
          // Accept of the held beat coincides with the final pop of the next one.
          ready = 1'b1;
          gate  = 1'b0;
          tick();
          chk({vecs[v].name, "_no_bubble_valid"}, {31'b0, bus.m_valid_o}, 32'h1);
          chk({vecs[v].name, "_no_bubble_data"}, bus.m_data_o, vecs[v].exp_beat[1]);
        end else begin
          gate = vecs[v].sparse && (c % 2 == 1);
          tick();
        end
      end
      run    = 0;
      broken = 1'b0;
      foreach (ren_hist[i]) begin
        if (!broken) begin
          if (ren_hist[i]) run++;
          else broken = 1'b1;
        end
      end
      chk({vecs[v].name, "_ren_run"}, 32'(run), 32'(vecs[v].exp_run));
      chk({vecs[v].name, "_nbeats"}, 32'(beats.size()), 32'(vecs[v].exp_nbeats));
      for (int b = 0; b < vecs[v].exp_nbeats; b++)
        chk({vecs[v].name, "_beat"}, (b < beats.size()) ? beats[b] : 32'hDEADBEEF, vecs[v].exp_beat[b]);
    end

    // Reset with two words accumulated and a stalled beat pending.
    do_reset();
    for (int k = 0; k < 6; k++) fifo_q.push_back(8'(8'h21 + k));
    repeat (8) tick();
    chk("pre_rst_valid", {31'b0, bus.m_valid_o}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst_ren", {31'b0, ren_hist[ren_hist.size()-1]}, 32'h0);
    chk("rst_valid", {31'b0, bus.m_valid_o}, 32'h0);
    chk("rst_data", bus.m_data_o, 32'h0);
    chk("rst_keep", {28'b0, bus.m_keep_o}, 32'h0);
    rst = 1'b0;
    beats.delete();
    ready = 1'b1;
    for (int k = 0; k < 4; k++) fifo_q.push_back(8'(8'hC1 + k));
    repeat (8) tick();
    chk("rst_nbeats", 32'(beats.size()), 32'h1);
    chk("rst_repack", (beats.size() != 0) ? beats[0] : 32'hDEADBEEF, 32'hC4C3C2C1);

    // Three words then a dry FIFO.
    do_reset();
    ready = 1'b1;
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    fifo_q.push_back(8'hA3);
    first      = -1;
    first_data = '0;
    first_keep = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (first < 0 && bus.m_valid_o) begin
        first      = c;
        first_data = bus.m_data_o;
        first_keep = bus.m_keep_o;
      end
    end
`ifdef PACK_TIMEOUT_EN
    chk("timeout_cycle", 32'(first), 32'd19);
    chk("timeout_data", first_data, 32'h00A3A2A1);
    chk("timeout_keep", {28'b0, first_keep}, 32'h7);
`else
    chk("no_timeout_valid", 32'(first), 32'hFFFFFFFF);
    chk("no_timeout_nbeats", 32'(beats.size()), 32'h0);
`endif

    // Randomised traffic with gaps, backpressure and occasional reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 3) != 0) fifo_q.push_back(8'($urandom));
      gate  = ($urandom_range(0, 4) == 0);
      ready = ($urandom_range(0, 2) != 0);
      if ((c % 500) >= 300 && (c % 500) < 320) ready = 1'b0;
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
